spi_target_device: RTL and testbench
====================================

// Module: spi_target_device
// PURPOSE
// SPI target (slave) endpoint: an external SPI controller clocks bytes in and out.
// Received bytes go into a small RX FIFO; one TX byte register feeds outgoing frames.
// Peripheral-bus responder, one per target lane, alongside the SPI controller devices.
// PARAMETERS
// ID          8'h01  device slot; selected when peripheralBus_address[15:8] == ID
// RX_DEPTH    4      RX FIFO entries, power of two, >= 2
// PORTS
// clk                       in   1   system clock
// rst                       in   1   asynchronous reset, active-low
// peripheralEnable          in   1   peripheral selected by PeripheralSelect
// peripheralBus_we          in   1   write strobe
// peripheralBus_oe          in   1   read strobe
// peripheralBus_busy        out  1   always 0 (single-cycle access)
// peripheralBus_address     in   16  local address
// peripheralBus_byteSelect  in   4   byte lanes; byte 0 qualifies every register write
// peripheralBus_dataWrite   in   32  write data
// peripheralBus_dataRead    out  32  read data; ~32'b0 when requestOutput = 0
// requestOutput             out  1   peripheralEnable & oe & slot hit & valid register
// spi_clk                   in   1   SCLK from external controller (mode 0 only)
// spi_cs                    in   1   chip select, active-low
// spi_mosi                  in   1   data in, MSB first
// spi_miso                  out  1   data out, MSB first
// spi_miso_en               out  1   1 = drive spi_miso; low when CS is high or block is disabled
// BEHAVIOUR
// - Reset: all regs 0. spi_miso = 0, spi_miso_en = 0, requestOutput = 0, FIFO empty, txEmpty = 1.
// - Registers (offset[7:0]): 0x00 CONFIG: bit0 enable (R/W).
//   0x04 STATUS (R): bit0 rxValid, bit1 rxOverflow (sticky; write 1 clears), bit2 txEmpty,
//   bit3 csActive, bits[7:4] rxCount. 0x08 RXDATA (R): [7:0] FIFO head, pops on read.
//   0x0C TXDATA (W): loads txReg, clears txEmpty. Other offsets: requestOutput = 0.
// - spi_clk, spi_cs and spi_mosi pass through 2-flop synchronisers. Edges are detected on the
//   synced SCLK. Requires f(clk) >= 4*f(SCLK).
// - While CONFIG.enable = 0: SPI inputs ignored, bitCount held at 0, miso_en = 0.
// - CS falling edge (synced): bitCount = 0.
//   txShift = txEmpty ? 8'hFF : txReg; txEmpty is set to 1; spi_miso = txShift[7] on the next clk.
// - SCLK rising edge: rxShift = {rxShift[6:0], mosi}; bitCount increments.
//   At count 8: push the byte and reset bitCount to 0.
// - SCLK falling edge: txShift shifts left. After the 8th bit (bitCount == 0),
//   txShift reloads from txReg (0xFF if txEmpty) and txEmpty is set.
// - CS rising edge mid-byte: the partial byte is discarded, bitCount = 0, miso_en drops next clk.
// - Push while full (no same-cycle pop): byte dropped, rxOverflow = 1.
//   Push and pop in the same cycle: both take effect; count unchanged.
// - Read RXDATA while empty: returns 0, no state change.
// - TXDATA write in the same cycle as a txShift load: the load takes the old txReg;
//   the new value is kept for the next frame (txEmpty ends 0).
// - Reset asserted mid-frame: everything returns to reset values immediately.
//   After release, the frame in progress is ignored until the next CS falling edge.
// STRUCTURE
// - Shared package/header: register offsets (CONFIG/STATUS/RXDATA/TXDATA) and STATUS bit indices.
//   These are also used by the controller-side SPIDevice firmware headers.
// - One sub-module: spi_target_rx_fifo (RX_DEPTH, 8-bit).
//   Ports: push, pop, full, empty, count, head. Pointers wrap modulo RX_DEPTH.
// - Synchronisers, edge detect, shift regs and bus decode live in this module.
// TESTING
// - Enable, TXDATA=0xA5. Controller sends 0x3C in mode 0 -> MISO bits 10100101;
//   STATUS rxValid=1, rxCount=1; RXDATA reads 0x3C.
// - TXDATA not written; send 2 bytes -> MISO returns 0xFF,0xFF; txEmpty stays 1.
// - Send 5 bytes 0x01..0x05 with no reads -> rxCount=4, rxOverflow=1; reads 0x01..0x04, then 0.
//   Write 0x2 to STATUS -> rxOverflow=0.
// - Raise CS after 5 bits of 0xFF, then send 0x81 in a new frame -> FIFO holds only 0x81.
// - CONFIG.enable=0, send 0x55 -> no push, miso_en=0.
//   Assert rst mid-byte -> all outputs 0 and FIFO empty.
// - Pop RXDATA in the same clk as a push when FIFO full -> no overflow, count stays 4.

Source files
------------

// File: rtl/spi_target_device_pkg.sv
// Register map and STATUS layout shared by the SPI target RTL and the controller-side firmware headers.
package spi_target_device_pkg;

    localparam logic [7:0] REG_CONFIG = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_RXDATA = 8'h08;
    localparam logic [7:0] REG_TXDATA = 8'h0C;

    localparam int STATUS_RX_VALID     = 0;
    localparam int STATUS_RX_OVERFLOW  = 1;
    localparam int STATUS_TX_EMPTY     = 2;
    localparam int STATUS_CS_ACTIVE    = 3;
    localparam int STATUS_RX_COUNT_LSB = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CONFIG,
        SEL_STATUS,
        SEL_RXDATA,
        SEL_TXDATA
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e sel;
        logic     readable;
    } reg_decode_t;

    // TXDATA is write-only, so a read of it is treated like an unmapped offset.
    function automatic reg_decode_t decode_offset(input logic [7:0] offset);
        reg_decode_t d;
        d.sel      = SEL_NONE;
        d.readable = 1'b0;
        case (offset)
            REG_CONFIG: begin d.sel = SEL_CONFIG; d.readable = 1'b1; end
            REG_STATUS: begin d.sel = SEL_STATUS; d.readable = 1'b1; end
            REG_RXDATA: begin d.sel = SEL_RXDATA; d.readable = 1'b1; end
            REG_TXDATA: begin d.sel = SEL_TXDATA; d.readable = 1'b0; end
            default:    ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/spi_target_rx_fifo.sv
// Byte-wide receive FIFO for the SPI target; pointers wrap naturally because RX_DEPTH is a power of two.
module spi_target_rx_fifo #(
    parameter int RX_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [7:0]                push_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(RX_DEPTH):0] count,
    output logic [7:0]                head
);
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(RX_DEPTH));
    assign empty = (count == '0);
    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_target_device.sv
// SPI target endpoint (mode 0) with a peripheral-bus register interface, RX FIFO and single TX byte register.
module spi_target_device
    import spi_target_device_pkg::*;
#(
    parameter logic [7:0] ID       = 8'h01,
    parameter int         RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peripheralEnable,
    input  logic        peripheralBus_we,
    input  logic        peripheralBus_oe,
    output logic        peripheralBus_busy,
    input  logic [15:0] peripheralBus_address,
    input  logic [3:0]  peripheralBus_byteSelect,
    input  logic [31:0] peripheralBus_dataWrite,
    output logic [31:0] peripheralBus_dataRead,
    output logic        requestOutput,
    input  logic        spi_clk,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_en
);
    localparam int CNT_W = $clog2(RX_DEPTH) + 1;

    logic [1:0]       sclk_sync, cs_sync, mosi_sync;
    logic             sclk_prev, cs_prev;
    logic             sclk_s, cs_s, mosi_s;
    logic             sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic             enable, frame_active, frame_go;
    logic [2:0]       bit_count;
    logic [6:0]       rx_shift;
    logic [7:0]       tx_shift, tx_reg, tx_next, push_data, status;
    logic             tx_empty, tx_load, rx_overflow;
    logic             push, pop, rx_full, rx_empty;
    logic [CNT_W-1:0] rx_count;
    logic [7:0]       rx_head;
    logic             slot_hit, bus_rd, bus_wr;
    reg_decode_t      dec;
    logic             unused_bits;

    assign unused_bits = ^{peripheralBus_dataWrite[31:8], peripheralBus_byteSelect[3:1]};

    // NOTE: every clocked process uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_clk};
            cs_sync   <= {cs_sync[0], spi_cs};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;

    // Only a frame that began with a CS falling edge while enabled is shifted.
    assign frame_go  = enable & frame_active & ~cs_rise & ~cs_fall;
    assign push_data = {rx_shift, mosi_s};
    assign push      = frame_go & sclk_rise & (bit_count == 3'd7);
    assign tx_next   = tx_empty ? 8'hFF : tx_reg;
    assign tx_load   = enable & (cs_fall | (frame_go & sclk_fall & (bit_count == 3'd0)));
    assign spi_miso  = spi_miso_en & tx_shift[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_active <= 1'b0;
            bit_count    <= '0;
            rx_shift     <= '0;
            tx_shift     <= '0;
            spi_miso_en  <= 1'b0;
        end else if (!enable || cs_rise) begin
            frame_active <= 1'b0;
            bit_count    <= '0;
            spi_miso_en  <= 1'b0;
        end else if (cs_fall) begin
            frame_active <= 1'b1;
            bit_count    <= '0;
            tx_shift     <= tx_next;
            spi_miso_en  <= 1'b1;
        end else if (frame_active) begin
            if (sclk_rise) begin
                rx_shift  <= push_data[6:0];
                bit_count <= bit_count + 3'd1;
            end else if (sclk_fall) begin
                tx_shift <= (bit_count == 3'd0) ? tx_next : {tx_shift[6:0], 1'b0};
            end
        end
    end

    spi_target_rx_fifo #(.RX_DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count),
        .head      (rx_head)
    );

    assign slot_hit           = (peripheralBus_address[15:8] == ID);
    assign dec                = decode_offset(peripheralBus_address[7:0]);
    assign bus_rd             = peripheralEnable & peripheralBus_oe & slot_hit & dec.readable;
    assign bus_wr             = peripheralEnable & peripheralBus_we & slot_hit & peripheralBus_byteSelect[0];
    assign pop                = bus_rd & (dec.sel == SEL_RXDATA);
    assign requestOutput      = bus_rd;
    assign peripheralBus_busy = 1'b0;
    assign status             = {4'(rx_count), ~cs_s, tx_empty, rx_overflow, ~rx_empty};

    // NOTE: the all-ones default keeps the read mux combinational with no latch on unmatched selects.
    always_comb begin
        peripheralBus_dataRead = '1;
        if (bus_rd) begin
            case (dec.sel)
                SEL_CONFIG: peripheralBus_dataRead = {31'd0, enable};
                SEL_STATUS: peripheralBus_dataRead = {24'd0, status};
                SEL_RXDATA: peripheralBus_dataRead = {24'd0, rx_empty ? 8'h00 : rx_head};
                default:    peripheralBus_dataRead = '1;
            endcase
        end
    end

    // A TXDATA write wins over a same-cycle load so the new byte survives for the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable      <= 1'b0;
            tx_reg      <= '0;
            tx_empty    <= 1'b1;
            rx_overflow <= 1'b0;
        end else begin
            if (bus_wr && dec.sel == SEL_CONFIG) enable <= peripheralBus_dataWrite[0];
            if (bus_wr && dec.sel == SEL_TXDATA) begin
                tx_reg   <= peripheralBus_dataWrite[7:0];
                tx_empty <= 1'b0;
            end else if (tx_load) begin
                tx_empty <= 1'b1;
            end
            if (push && rx_full && !pop) begin
                rx_overflow <= 1'b1;
            end else if (bus_wr && dec.sel == SEL_STATUS && peripheralBus_dataWrite[STATUS_RX_OVERFLOW]) begin
                rx_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_target_device.sv
// Self-checking bench: drives mode-0 SPI frames and bus accesses against a byte-level reference model.
module tb_spi_target_device;
    import spi_target_device_pkg::*;

    localparam logic [7:0] ID    = 8'h01;
    localparam int         DEPTH = 4;
    localparam int         H     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        peripheralEnable = 1'b0;
    logic        peripheralBus_we = 1'b0;
    logic        peripheralBus_oe = 1'b0;
    logic        peripheralBus_busy;
    logic [15:0] peripheralBus_address = '0;
    logic [3:0]  peripheralBus_byteSelect = '0;
    logic [31:0] peripheralBus_dataWrite = '0;
    logic [31:0] peripheralBus_dataRead;
    logic        requestOutput;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_en;

    always #5 clk = ~clk;

    spi_target_device #(.ID(ID), .RX_DEPTH(DEPTH)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (peripheralEnable),
        .peripheralBus_we         (peripheralBus_we),
        .peripheralBus_oe         (peripheralBus_oe),
        .peripheralBus_busy       (peripheralBus_busy),
        .peripheralBus_address    (peripheralBus_address),
        .peripheralBus_byteSelect (peripheralBus_byteSelect),
        .peripheralBus_dataWrite  (peripheralBus_dataWrite),
        .peripheralBus_dataRead   (peripheralBus_dataRead),
        .requestOutput            (requestOutput),
        .spi_clk                  (spi_clk),
        .spi_cs                   (spi_cs),
        .spi_mosi                 (spi_mosi),
        .spi_miso                 (spi_miso),
        .spi_miso_en              (spi_miso_en)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register-level state plus a queue standing in for the RX FIFO.
    logic [7:0]  m_rx_q[$];
    logic        m_ovf = 1'b0;
    logic [7:0]  m_tx_reg = 8'h00;
    logic        m_tx_empty = 1'b1;
    logic        m_enable = 1'b0;

    logic [7:0]  mosi_q[$];
    logic [7:0]  miso_got[$];
    logic [7:0]  miso_exp[$];
    logic        en_all, en_any;
    logic [31:0] aligned_rd, exp_aligned;

    function automatic logic [31:0] exp_status(input logic cs_act);
        logic [3:0] c;
        c = 4'(m_rx_q.size());
        return {24'h0, c, cs_act, m_tx_empty, m_ovf, (m_rx_q.size() != 0)};
    endfunction

    function automatic logic [31:0] model_pop();
        if (m_rx_q.size() == 0) return 32'h0;
        return {24'h0, m_rx_q.pop_front()};
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [7:0] model_take_tx();
        logic [7:0] t;
        t = m_tx_empty ? 8'hFF : m_tx_reg;
        m_tx_empty = 1'b1;
        return t;
    endfunction

    task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] be);
        @(negedge clk);
        peripheralEnable         = 1'b1;
        peripheralBus_we         = 1'b1;
        peripheralBus_address    = {ID, off};
        peripheralBus_byteSelect = be;
        peripheralBus_dataWrite  = data;
        @(negedge clk);
        peripheralEnable = 1'b0;
        peripheralBus_we = 1'b0;
        if (be[0]) begin
            if (off == REG_CONFIG) m_enable = data[0];
            if (off == REG_STATUS && data[1]) m_ovf = 1'b0;
            if (off == REG_TXDATA) begin m_tx_reg = data[7:0]; m_tx_empty = 1'b0; end
        end
    endtask

    task automatic bus_read(input logic [7:0] slot, input logic [7:0] off,
                            output logic [31:0] data, output logic req);
        @(negedge clk);
        peripheralEnable      = 1'b1;
        peripheralBus_oe      = 1'b1;
        peripheralBus_address = {slot, off};
        #1;
        data = peripheralBus_dataRead;
        req  = requestOutput;
        @(negedge clk);
        peripheralEnable = 1'b0;
        peripheralBus_oe = 1'b0;
    endtask

    // Shifts nbits of b MSB first; MISO is sampled just before each rising SCLK edge.
    task automatic spi_byte(input logic [7:0] b, input int nbits, input bit pop_last, output logic [7:0] mb);
        mb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            spi_mosi = b[7-i];
            repeat (H) @(negedge clk);
            mb     = {mb[6:0], spi_miso};
            en_all = en_all & spi_miso_en;
            en_any = en_any | spi_miso_en;
            spi_clk = 1'b1;
            if (pop_last && i == 7) begin
                // Two synchroniser stages later the push lands; read RXDATA in exactly that cycle.
                @(posedge clk);
                @(posedge clk);
                @(negedge clk);
                peripheralEnable      = 1'b1;
                peripheralBus_oe      = 1'b1;
                peripheralBus_address = {ID, REG_RXDATA};
                #1 aligned_rd = peripheralBus_dataRead;
                @(negedge clk);
                peripheralEnable = 1'b0;
                peripheralBus_oe = 1'b0;
                repeat (H - 3) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_frame(input int partial_bits, input bit pop_last);
        logic [7:0] mb, cur;
        int n;
        n = mosi_q.size();
        cur = 8'hFF;
        miso_got.delete();
        miso_exp.delete();
        en_all = 1'b1;
        en_any = 1'b0;
        @(negedge clk);
        spi_cs = 1'b0;
        if (m_enable) cur = model_take_tx();
        repeat (H) @(negedge clk);
        for (int k = 0; k < n; k++) begin
            spi_byte(mosi_q[k], 8, pop_last && (k == n - 1), mb);
            miso_got.push_back(mb);
            if (m_enable) begin
                miso_exp.push_back(cur);
                if (pop_last && k == n - 1) exp_aligned = model_pop();
                model_push(mosi_q[k]);
                cur = model_take_tx();
            end
        end
        if (partial_bits > 0) spi_byte(8'hFF, partial_bits, 1'b0, mb);
        repeat (H) @(negedge clk);
        spi_cs = 1'b1;
        repeat (2 * H) @(negedge clk);
        mosi_q.delete();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic r;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi_miso, spi_miso_en, requestOutput, peripheralBus_busy} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {spi_miso, spi_miso_en, requestOutput, peripheralBus_busy});
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h04 || r !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_status: got %h req %b expected 00000004 req 1", d, r);
        end
        bus_read(ID, REG_CONFIG, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_config: got %h expected 0", d); end
        bus_read(ID, REG_RXDATA, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL reset_rxdata_empty: got %h expected 0", d); end
    endtask

    task automatic test_bus_decode();
        logic [31:0] d;
        logic r;
        bus_read(ID, 8'h10, d, r);
        n_checks++;
        if (r !== 1'b0 || d !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL bad_offset: got %h req %b expected ffffffff req 0", d, r);
        end
        bus_read(8'h02, REG_STATUS, d, r);
        n_checks++;
        if (r !== 1'b0 || d !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL wrong_slot: got %h req %b expected ffffffff req 0", d, r);
        end
        bus_write(REG_CONFIG, 32'h1, 4'hE);
        bus_read(ID, REG_CONFIG, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL byte0_qualifier: got %h expected 0", d); end
        bus_write(REG_CONFIG, 32'h1, 4'hF);
        bus_read(ID, REG_CONFIG, d, r);
        n_checks++;
        if (d !== 32'h1) begin n_errors++; $display("FAIL config_enable: got %h expected 1", d); end
    endtask

    task automatic test_basic_transfer();
        logic [31:0] d;
        logic r;
        bus_write(REG_TXDATA, 32'hA5, 4'hF);
        mosi_q.push_back(8'h3C);
        send_frame(0, 1'b0);
        n_checks++;
        if (miso_got[0] !== 8'hA5 || en_all !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_miso: got %h en %b expected a5 en 1", miso_got[0], en_all);
        end
        n_checks++;
        if (spi_miso_en !== 1'b0) begin n_errors++; $display("FAIL miso_en_idle: got %b expected 0", spi_miso_en); end
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h15) begin n_errors++; $display("FAIL basic_status: got %h expected 15", d); end
        void'(model_pop());
        bus_read(ID, REG_RXDATA, d, r);
        n_checks++;
        if (d !== 32'h3C) begin n_errors++; $display("FAIL basic_rxdata: got %h expected 3c", d); end
    endtask

    task automatic test_tx_empty();
        logic [31:0] d, e;
        logic r;
        mosi_q.push_back(8'($urandom));
        mosi_q.push_back(8'($urandom));
        send_frame(0, 1'b0);
        n_checks++;
        if (miso_got[0] !== 8'hFF || miso_got[1] !== 8'hFF) begin
            n_errors++;
            $display("FAIL tx_empty_miso: got %h %h expected ff ff", miso_got[0], miso_got[1]);
        end
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h25) begin n_errors++; $display("FAIL tx_empty_status: got %h expected 25", d); end
        for (int i = 0; i < 2; i++) begin
            e = model_pop();
            bus_read(ID, REG_RXDATA, d, r);
            n_checks++;
            if (d !== e) begin n_errors++; $display("FAIL tx_empty_drain: got %h expected %h", d, e); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic r;
        for (int i = 1; i <= 5; i++) mosi_q.push_back(8'(i));
        send_frame(0, 1'b0);
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h47) begin n_errors++; $display("FAIL overflow_status: got %h expected 47", d); end
        for (int i = 1; i <= 5; i++) begin
            void'(model_pop());
            bus_read(ID, REG_RXDATA, d, r);
            n_checks++;
            if (d !== ((i <= 4) ? 32'(i) : 32'h0)) begin
                n_errors++;
                $display("FAIL overflow_read%0d: got %h expected %h", i, d, (i <= 4) ? 32'(i) : 32'h0);
            end
        end
        bus_write(REG_STATUS, 32'h2, 4'hF);
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h04) begin n_errors++; $display("FAIL overflow_clear: got %h expected 04", d); end
    endtask

    task automatic test_partial_frame();
        logic [31:0] d;
        logic r;
        send_frame(5, 1'b0);
        mosi_q.push_back(8'h81);
        send_frame(0, 1'b0);
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h15) begin n_errors++; $display("FAIL partial_status: got %h expected 15", d); end
        void'(model_pop());
        bus_read(ID, REG_RXDATA, d, r);
        n_checks++;
        if (d !== 32'h81) begin n_errors++; $display("FAIL partial_rxdata: got %h expected 81", d); end
        bus_read(ID, REG_RXDATA, d, r);
        n_checks++;
        if (d !== 32'h0) begin n_errors++; $display("FAIL partial_empty: got %h expected 0", d); end
    endtask

    task automatic test_back_to_back_pop_push();
        logic [31:0] d, e;
        logic r;
        for (int i = 0; i < 4; i++) mosi_q.push_back(8'hA1 + 8'(i));
        send_frame(0, 1'b0);
        mosi_q.push_back(8'hA5);
        send_frame(0, 1'b1);
        n_checks++;
        if (aligned_rd !== exp_aligned || exp_aligned !== 32'hA1) begin
            n_errors++;
            $display("FAIL same_cycle_pop: got %h expected a1", aligned_rd);
        end
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h45) begin n_errors++; $display("FAIL same_cycle_status: got %h expected 45", d); end
        for (int i = 0; i < 4; i++) begin
            e = model_pop();
            bus_read(ID, REG_RXDATA, d, r);
            n_checks++;
            if (d !== e) begin n_errors++; $display("FAIL same_cycle_drain: got %h expected %h", d, e); end
        end
    endtask

    task automatic test_disabled();
        logic [31:0] d;
        logic r;
        bus_write(REG_CONFIG, 32'h0, 4'hF);
        mosi_q.push_back(8'h55);
        send_frame(0, 1'b0);
        n_checks++;
        if (en_any !== 1'b0) begin n_errors++; $display("FAIL disabled_miso_en: got %b expected 0", en_any); end
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== exp_status(1'b0)) begin
            n_errors++;
            $display("FAIL disabled_status: got %h expected %h", d, exp_status(1'b0));
        end
        bus_write(REG_CONFIG, 32'h1, 4'hF);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d, e;
        logic [7:0] mb;
        logic r;
        bus_write(REG_TXDATA, 32'h5A, 4'hF);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (H) @(negedge clk);
        spi_byte(8'hC3, 4, 1'b0, mb);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({spi_miso, spi_miso_en, requestOutput} !== 3'b000) begin
            n_errors++;
            $display("FAIL midframe_reset_outputs: got %b expected 000", {spi_miso, spi_miso_en, requestOutput});
        end
        m_rx_q.delete();
        m_ovf      = 1'b0;
        m_tx_reg   = 8'h00;
        m_tx_empty = 1'b1;
        m_enable   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h0C) begin n_errors++; $display("FAIL midframe_status: got %h expected 0c", d); end
        bus_write(REG_CONFIG, 32'h1, 4'hF);
        en_any = 1'b0;
        spi_byte(8'h3C, 4, 1'b0, mb);
        spi_byte(8'h77, 8, 1'b0, mb);
        repeat (H) @(negedge clk);
        spi_cs = 1'b1;
        repeat (2 * H) @(negedge clk);
        n_checks++;
        if (en_any !== 1'b0) begin n_errors++; $display("FAIL midframe_ignored_en: got %b expected 0", en_any); end
        bus_read(ID, REG_STATUS, d, r);
        n_checks++;
        if (d !== 32'h04) begin n_errors++; $display("FAIL midframe_ignored: got %h expected 04", d); end
        mosi_q.push_back(8'h12);
        send_frame(0, 1'b0);
        e = model_pop();
        bus_read(ID, REG_RXDATA, d, r);
        n_checks++;
        if (d !== e || e !== 32'h12) begin n_errors++; $display("FAIL midframe_next_frame: got %h expected 12", d); end
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic r;
        int nb, nr;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(1, 0) == 1) bus_write(REG_TXDATA, 32'($urandom_range(255, 0)), 4'hF);
            nb = $urandom_range(3, 1);
            for (int k = 0; k < nb; k++) mosi_q.push_back(8'($urandom_range(255, 0)));
            send_frame(0, 1'b0);
            for (int k = 0; k < nb; k++) begin
                n_checks++;
                if (miso_got[k] !== miso_exp[k]) begin
                    n_errors++;
                    $display("FAIL rand_miso it%0d b%0d: got %h expected %h", it, k, miso_got[k], miso_exp[k]);
                end
            end
            n_checks++;
            if (en_all !== 1'b1) begin n_errors++; $display("FAIL rand_miso_en it%0d: got 0 expected 1", it); end
            nr = $urandom_range(3, 0);
            for (int k = 0; k < nr; k++) begin
                e = model_pop();
                bus_read(ID, REG_RXDATA, d, r);
                n_checks++;
                if (d !== e) begin n_errors++; $display("FAIL rand_rxdata it%0d: got %h expected %h", it, d, e); end
            end
            bus_read(ID, REG_STATUS, d, r);
            n_checks++;
            if (d !== exp_status(1'b0)) begin
                n_errors++;
                $display("FAIL rand_status it%0d: got %h expected %h", it, d, exp_status(1'b0));
            end
            if (m_ovf && $urandom_range(1, 0) == 1) bus_write(REG_STATUS, 32'h2, 4'hF);
        end
    endtask

    initial begin
        test_reset();
        test_bus_decode();
        test_basic_transfer();
        test_tx_empty();
        test_overflow();
        test_partial_frame();
        test_back_to_back_pop_push();
        test_disabled();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
